// File: rtl/pc_fetch_pkg.sv
// Shared CPU constants: next-PC select encodings and the reset fetch address.
package pc_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'b00,
      NPC_BR  = 2'b01,
      NPC_J   = 2'b10,
      NPC_JR  = 2'b11
   } npc_op_e;

endpackage

// File: rtl/pc_fetch_npc.sv
// Combinational next-PC select for the instruction currently in ID.
module pc_fetch_npc
   import pc_fetch_pkg::*;
(
   input  logic [31:0] pc_f,
   input  logic [31:0] pc_d,
   input  logic [25:0] instr_idx,
   input  logic [1:0]  npc_op,
   input  logic        br,
   input  logic [31:0] reg_a,
   output logic [31:0] npc
);

   logic [31:0] pc_d_plus4;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] jr_target;

   always_comb begin
      pc_d_plus4 = pc_d + 32'd4;
      br_target  = pc_d_plus4 + {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
      j_target   = {pc_d_plus4[31:28], instr_idx, 2'b00};
      // jr targets are word-aligned; stray low bits of rs are dropped
      jr_target  = reg_a & 32'hFFFF_FFFC;

      npc = pc_f + 32'd4;
      case (npc_op)
         NPC_BR:  if (br) npc = br_target;
         NPC_J:   npc = j_target;
         NPC_JR:  npc = jr_target;
         default: npc = pc_f + 32'd4;
      endcase
   end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: PC register and IF/ID pipeline register with hazard stall.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic [1:0]  NPCOp,
   input  logic        Br,
   input  logic [31:0] RegA,
   input  logic [31:0] Instr_F,
   output logic [31:0] PC_F,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC8_D
);

   logic [31:0] pc_f_q,    pc_f_d;
   logic [31:0] instr_d_q, instr_d_d;
   logic [31:0] pc_d_q,    pc_d_d;
   logic [31:0] npc;

   pc_fetch_npc u_npc (
      .pc_f      (pc_f_q),
      .pc_d      (pc_d_q),
      .instr_idx (instr_d_q[25:0]),
      .npc_op    (NPCOp),
      .br        (Br),
      .reg_a     (RegA),
      .npc       (npc)
   );

   // A stall holds everything, so a redirect in ID is simply recomputed later.
   always_comb begin
      pc_f_d    = pc_f_q;
      instr_d_d = instr_d_q;
      pc_d_d    = pc_d_q;
      if (!Stall) begin
         pc_f_d    = npc;
         instr_d_d = Instr_F;
         pc_d_d    = pc_f_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f_q    <= RESET_PC;
         instr_d_q <= NOP_INSTR;
         pc_d_q    <= RESET_PC;
      end else begin
         pc_f_q    <= pc_f_d;
         instr_d_q <= instr_d_d;
         pc_d_q    <= pc_d_d;
      end
   end

   assign PC_F    = pc_f_q;
   assign Instr_D = instr_d_q;
   assign PC_D    = pc_d_q;
   assign PC8_D   = pc_d_q + 32'd8;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed scenarios followed by random traffic.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        Stall;
   logic [1:0]  NPCOp;
   logic        Br;
   logic [31:0] RegA;
   logic [31:0] Instr_F;
   logic [31:0] PC_F;
   logic [31:0] Instr_D;
   logic [31:0] PC_D;
   logic [31:0] PC8_D;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   pc_fetch #(.RESET_PC(RST_PC)) dut (
      .clk     (clk),
      .reset   (reset),
      .Stall   (Stall),
      .NPCOp   (NPCOp),
      .Br      (Br),
      .RegA    (RegA),
      .Instr_F (Instr_F),
      .PC_F    (PC_F),
      .Instr_D (Instr_D),
      .PC_D    (PC_D),
      .PC8_D   (PC8_D)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned tgt;
      logic [31:0] pc_f;
      logic [31:0] instr_d;
      logic [31:0] pc_d;
      logic [31:0] pc8_d;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   logic [31:0] m_pc_f, m_instr_d, m_pc_d;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference next-PC from the architectural rules, in plain arithmetic.
   function automatic logic [31:0] ref_npc(input logic [1:0] op, input logic br,
                                           input logic [31:0] rega);
      logic [31:0] off;
      logic [31:0] idx;
      off = {{16{m_instr_d[15]}}, m_instr_d[15:0]};
      idx = {6'd0, m_instr_d[25:0]};
      if (op == 2'd1 && br) return m_pc_d + 32'd4 + off * 32'd4;
      if (op == 2'd2)       return ((m_pc_d + 32'd4) & 32'hF000_0000) + idx * 32'd4;
      if (op == 2'd3)       return (rega / 32'd4) * 32'd4;
      return m_pc_f + 32'd4;
   endfunction

   task automatic step(input logic rst, input logic stall, input logic [1:0] op,
                       input logic br, input logic [31:0] rega, input logic [31:0] instr);
      exp_t e;
      logic [31:0] nxt;
      reset = rst; Stall = stall; NPCOp = op; Br = br; RegA = rega; Instr_F = instr;
      if (rst) begin
         m_pc_f = RST_PC; m_instr_d = 32'h0; m_pc_d = RST_PC;
      end else if (!stall) begin
         nxt       = ref_npc(op, br, rega);
         m_pc_d    = m_pc_f;
         m_instr_d = instr;
         m_pc_f    = nxt;
      end
      e.tgt = cyc + 1; e.pc_f = m_pc_f; e.instr_d = m_instr_d;
      e.pc_d = m_pc_d; e.pc8_d = m_pc_d + 32'd8;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            e = sb.pop_front();
            check("sb_tgt",     cyc,     e.tgt);
            check("sb_PC_F",    PC_F,    e.pc_f);
            check("sb_Instr_D", Instr_D, e.instr_d);
            check("sb_PC_D",    PC_D,    e.pc_d);
            check("sb_PC8_D",   PC8_D,   e.pc8_d);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   localparam logic [31:0] BEQ_M2 = 32'h1000_FFFE;
   localparam logic [31:0] J_C10  = 32'h0800_0C10;
   localparam logic [31:0] SLOT   = 32'hAAAA_5555;

   initial begin : stim
      step(1, 0, 2'd0, 0, 32'h0, 32'h1234_5678);
      check("rst_PC_F", PC_F, 32'h0000_3000);
      check("rst_Instr_D", Instr_D, 32'h0);
      check("rst_PC_D", PC_D, 32'h0000_3000);

      // sequential fetch, PC_D trails by one
      step(0, 0, 2'd0, 0, 32'h0, 32'h1111_0000);
      check("seq1_PC_F", PC_F, 32'h0000_3004);
      check("seq1_PC_D", PC_D, 32'h0000_3000);
      step(0, 0, 2'd0, 0, 32'h0, BEQ_M2);
      check("seq2_PC_F", PC_F, 32'h0000_3008);
      check("seq2_PC_D", PC_D, 32'h0000_3004);
      // taken branch back to 3000, delay slot enters IF/ID
      step(0, 0, 2'd1, 1, 32'h0, SLOT);
      check("br_taken_PC_F", PC_F, 32'h0000_3000);
      check("br_delay_slot", Instr_D, SLOT);
      check("br_slot_PC_D", PC_D, 32'h0000_3008);

      step(1, 0, 2'd0, 0, 32'h0, 32'h0);
      step(0, 0, 2'd0, 0, 32'h0, 32'h0);
      step(0, 0, 2'd0, 0, 32'h0, BEQ_M2);
      step(0, 0, 2'd1, 0, 32'h0, SLOT);
      check("br_not_taken_PC_F", PC_F, 32'h0000_300C);

      // jump, then jr
      step(1, 0, 2'd0, 0, 32'h0, 32'h0);
      step(0, 0, 2'd0, 0, 32'h0, J_C10);
      check("j_PC8_D", PC8_D, 32'h0000_3008);
      step(0, 0, 2'd2, 0, 32'h0, SLOT);
      check("j_PC_F", PC_F, 32'h0000_3040);
      step(0, 0, 2'd3, 0, 32'h0000_3107, 32'h0);
      check("jr_PC_F", PC_F, 32'h0000_3104);

      // 32-bit wrap of PC_F and PC8_D
      step(0, 0, 2'd3, 0, 32'hFFFF_FFFF, 32'h0);
      check("jr_top_PC_F", PC_F, 32'hFFFF_FFFC);
      step(0, 0, 2'd0, 0, 32'h0, 32'h0);
      check("wrap_PC_F", PC_F, 32'h0000_0000);
      check("wrap_PC8_D", PC8_D, 32'h0000_0004);

      // stall with a taken branch pending in ID
      step(1, 0, 2'd0, 0, 32'h0, 32'h0);
      step(0, 0, 2'd0, 0, 32'h0, BEQ_M2);
      step(0, 1, 2'd1, 1, 32'h0, SLOT);
      step(0, 1, 2'd1, 1, 32'h0, SLOT);
      check("stall_PC_F", PC_F, 32'h0000_3004);
      check("stall_Instr_D", Instr_D, BEQ_M2);
      check("stall_PC_D", PC_D, 32'h0000_3000);
      step(0, 0, 2'd1, 1, 32'h0, SLOT);
      check("stall_redirect_PC_F", PC_F, 32'h0000_2FFC);

      // reset wins over stall and a pending redirect
      step(0, 0, 2'd0, 0, 32'h0, BEQ_M2);
      step(1, 1, 2'd1, 1, 32'h0, SLOT);
      check("rst_stall_PC_F", PC_F, 32'h0000_3000);
      check("rst_stall_Instr_D", Instr_D, 32'h0);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 25),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom, $urandom);
      end

      reset = 0; Stall = 1;
      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC_F value after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Stall  input  1  hazard-unit hold; freezes the PC register and the IF/ID register.
REQ-005 NPCOp  input  2  next-PC select for the ID instruction: 00 seq, 01 cond-branch, 10 j/jal, 11 jr.
REQ-006 Br  input  1  branch-taken flag from the ID-stage comparator; meaningful only when NPCOp=01.
REQ-007 RegA  input  32  forwarded rs value in ID (jr target).
REQ-008 Instr_F  input  32  instruction word returned by instruction memory for PC_F.
REQ-009 PC_F  output  32  current fetch address to instruction memory.
REQ-010 Instr_D  output  32  IF/ID instruction register.
REQ-011 PC_D  output  32  IF/ID PC register (address of Instr_D).
REQ-012 PC8_D  output  32  PC_D+8, the link value for jal.

Function
REQ-013 The branch target SHALL be PC_D+4+(sign-extended Instr_D[15:0] << 2), with mod-2^32 wrap.
REQ-014 The j/jal target SHALL be {PC_D[31:28]+carry of PC_D+4, Instr_D[25:0], 2'b00}, i.e. {(PC_D+4)[31:28], index, 00}.
REQ-015 The jr target SHALL be {RegA[31:2], 2'b00}; the low bits are silently cleared.
REQ-016 Next PC SHALL be: NPCOp=01 and Br=1 -> branch target; 10 -> jump target; 11 -> jr target; all other cases -> PC_F+4.
REQ-017 With Stall=0, each rising edge SHALL load PC_F <= next PC, Instr_D <= Instr_F, PC_D <= PC_F.
REQ-018 With Stall=1, PC_F, Instr_D and PC_D SHALL hold; a redirect pending in ID is re-evaluated on the first unstalled cycle.
REQ-019 Delay slot: the instruction fetched in the cycle the redirect is decided SHALL enter IF/ID normally; no flush is generated.
REQ-020 Latency: a redirect decided in cycle n SHALL appear on PC_F in cycle n+1.
REQ-021 PC8_D SHALL be combinational from PC_D, with 32-bit wrap.
REQ-022 NPCOp=01 with Br=0 SHALL behave exactly as NPCOp=00.

Reset
REQ-023 When reset=1 at an edge, the block SHALL load PC_F=RESET_PC, Instr_D=32'h0 (nop) and PC_D=RESET_PC, regardless of Stall, NPCOp or Br.
REQ-024 Reset asserted mid-stall or mid-redirect SHALL discard the pending state; no redirect survives reset.

Structure
REQ-025 The NPCOp encodings and the RESET_PC default SHALL live in the shared CPU constants package used by the decoder and the comparator.
REQ-026 The next-PC computation SHALL be a combinational sub-module npc; pc_fetch holds only the PC and IF/ID registers.

Verification
REQ-027 Reset, then 3 unstalled cycles, NPCOp=00 -> PC_F = 3000, 3004, 3008, 300C; PC_D trails PC_F by one cycle.
REQ-028 PC_D=3004, Instr_D imm=16'hFFFE, NPCOp=01, Br=1 -> next PC_F=3000; the delay slot 3008 is in Instr_D; with Br=0 -> PC_F=300C.
REQ-029 PC_D=3000, j index=26'h0000C10, NPCOp=10 -> PC_F=3040 after one edge; PC8_D=3008 while that j is in ID.
REQ-030 NPCOp=11, RegA=32'h0000_3107 -> PC_F=3104.
REQ-031 Stall=1 for 2 cycles with a taken branch in ID -> PC_F and IF/ID hold; the redirect occurs on the first cycle with Stall=0.
REQ-032 reset=1 together with Stall=1 and a taken branch -> PC_F=3000, Instr_D=0 on the next edge.
